// File: rtl/mips_pkg.sv
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared types and constants for the instruction fetch stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BNE    = 6'h05;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// Module  : next_pc_calc
// Purpose : Combinational next-PC selection (register jump, J/JAL, BNE, +4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] instr_i,
    input  logic        jump_i,
    input  logic        jal_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic [31:0] reg_target_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic [31:0] branch_off;
    logic [31:0] jump_tgt;

    assign branch_off = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
    assign jump_tgt   = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_i && (instr_i[31:26] == R_TYPE)) begin
            next_pc_o = reg_target_i;
        end else if (jump_i || jal_i) begin
            next_pc_o = jump_tgt;
        end else if (branch_i && !zero_i) begin
            next_pc_o = pc_plus4_i + branch_off;
        end
    end

    // Only the register jump can produce a misaligned target.
    assign misaligned_o = (next_pc_o[1:0] != 2'b00);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Purpose : PC register, imem req/ack fetch FSM and instruction register.
//           Optional misaligned-target trap enabled by FETCH_ALIGN_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic        branch,
    input  logic        jal,
    input  logic        zero,
    input  logic [31:0] reg_target,
    input  logic        advance,
    output logic        fetch_err
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic         valid_q;
    logic         req_q;
    logic [31:0]  next_pc_d;
    logic         misaligned;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_calc u_next_pc_calc (
        .pc_plus4_i   (pc_plus4),
        .instr_i      (instr_q),
        .jump_i       (jump),
        .jal_i        (jal),
        .branch_i     (branch),
        .zero_i       (zero),
        .reg_target_i (reg_target),
        .next_pc_o    (next_pc_d),
        .misaligned_o (misaligned)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ack) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (advance) begin
                        valid_q <= 1'b0;
                        if (misaligned) begin
                            err_q   <= 1'b1;
                            state_q <= HALT;
                        end else begin
                            pc_q    <= next_pc_d;
                            req_q   <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                HALT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: state_q <= HALT;
            endcase
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (imem_ack) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (advance) begin
                        // Without the trap, targets are silently word-aligned.
                        pc_q    <= {next_pc_d[31:2], 2'b00};
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign fetch_err = 1'b0;
`endif

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign instr_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Purpose : Directed self-checking bench for fetch_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        jump;
    logic        branch;
    logic        jal;
    logic        zero;
    logic [31:0] reg_target;
    logic        advance;
    logic        fetch_err;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] W_ADDI = 32'h2008_0005;
    localparam logic [31:0] W_NOP  = 32'h0000_0000;
    localparam logic [31:0] W_BNE  = 32'h1422_FFFE;
    localparam logic [31:0] W_JR   = 32'h03E0_0008;
    localparam logic [31:0] W_JAL  = 32'h0C00_0040;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .instr       (instr),
        .opcode      (opcode),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .jump        (jump),
        .branch      (branch),
        .jal         (jal),
        .zero        (zero),
        .reg_target  (reg_target),
        .advance     (advance),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for imem_req, lets lat cycles pass, then acks for one cycle.
    task automatic fetch(input string tag, input logic [31:0] word, input int lat);
        int guard = 0;
        while (imem_req !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        repeat (lat) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = word;
        chk({tag, "_valid_in_ack"}, {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, word);
    endtask

    task automatic exec(input string tag, input logic j, input logic b, input logic l,
                        input logic z, input logic [31:0] rt, input logic [31:0] exp_pc);
        jump = j; branch = b; jal = l; zero = z; reg_target = rt;
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0; jump = 1'b0; branch = 1'b0; jal = 1'b0; zero = 1'b0;
        chk({tag, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; advance = 1'b0;
        jump = 1'b0; branch = 1'b0; jal = 1'b0; zero = 1'b0; reg_target = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_pc", pc, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'd0);
        fetch("addi", W_ADDI, 2);
        chk("addi_req_low", {31'd0, imem_req}, 32'd0);
        chk("addi_opcode", {26'd0, opcode}, 32'h08);
        chk("addi_funct", {26'd0, funct}, 32'h05);
        exec("addi_adv", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd4);
        chk("adv_req", {31'd0, imem_req}, 32'd1);
        chk("adv_valid", {31'd0, instr_valid}, 32'd0);

        // BNE at pc=8, offset -2 words.
        fetch("nop4", W_NOP, 0);
        exec("nop4_adv", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd8);
        fetch("bne_t", W_BNE, 1);
        exec("bne_taken", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd4);
        fetch("nop4b", W_NOP, 0);
        exec("nop4b_adv", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd8);
        fetch("bne_n", W_BNE, 0);
        exec("bne_not", 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd12);

        // Register jump to 0x1000_0010, then JAL there.
        fetch("jr1", W_JR, 0);
        exec("jr1_adv", 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0010, 32'h1000_0010);
        fetch("jal", W_JAL, 0);
        chk("jal_pc_plus4", pc_plus4, 32'h1000_0014);
        exec("jal_adv", 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h1000_0100);
        fetch("jr2", W_JR, 0);
        exec("jr2_adv", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'h0000_0200);

        // Ack together with req, advance held high: one instruction per 2 cycles.
        imem_ack = 1'b1; imem_rdata = W_NOP; advance = 1'b1;
        @(negedge clk);
        chk("b2b_valid0", {31'd0, instr_valid}, 32'd1);
        chk("b2b_pc0", pc, 32'h200);
        @(negedge clk);
        chk("b2b_req1", {31'd0, imem_req}, 32'd1);
        chk("b2b_pc1", pc, 32'h204);
        @(negedge clk);
        chk("b2b_valid1", {31'd0, instr_valid}, 32'd1);
        @(negedge clk);
        chk("b2b_pc2", pc, 32'h208);
        imem_ack = 1'b0; advance = 1'b0;

        // Misaligned register target.
        fetch("jr3", W_JR, 0);
`ifdef FETCH_ALIGN_CHECK_EN
        exec("jr3_adv", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0202, 32'h0000_0208);
        chk("trap_err", {31'd0, fetch_err}, 32'd1);
        repeat (2) @(negedge clk);
        chk("halt_req", {31'd0, imem_req}, 32'd0);
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_err", {31'd0, fetch_err}, 32'd1);
`else
        exec("jr3_adv", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0202, 32'h0000_0200);
        chk("noerr", {31'd0, fetch_err}, 32'd0);
        chk("noerr_req", {31'd0, imem_req}, 32'd1);
`endif

        // Asynchronous reset during FETCH with an ack pending.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch("pre_rst", W_NOP, 0);
        exec("pre_rst_adv", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd4);
        imem_ack = 1'b1; imem_rdata = W_ADDI;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_pc", pc, 32'd0);
        chk("async_err", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("async_discard", {31'd0, instr_valid}, 32'd0);
        chk("async_instr", instr, 32'd0);

        // Wrap-around from 0xFFFF_FFFC.
        fetch("jr4", W_JR, 0);
        exec("jr4_adv", 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch("wrap", W_NOP, 0);
        chk("wrap_pc_plus4", pc_plus4, 32'd0);
        exec("wrap_adv", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("wrap_err", {31'd0, fetch_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `control`. Holds the PC, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents `opcode`/`funct` to `control`. Computes the next PC from control's `jump`/`branch`/`jal` and the datapath's `zero` and register target, then advances once the datapath retires the instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_req` out 1: fetch request, held until ack.
- `imem_addr` out 32: fetch address, equal to `pc`.
- `imem_rdata` in 32: instruction word, valid in the `imem_ack` cycle.
- `imem_ack` in 1: memory completion; may arrive in the same cycle `imem_req` rises.
- `instr` out 32: latched instruction.
- `opcode` out 6: `instr[31:26]`, to control `instruction`.
- `funct` out 6: `instr[5:0]`, to control `funct`.
- `instr_valid` out 1: `instr` is valid and is executing.
- `pc` out 32: address of the current instruction.
- `pc_plus4` out 32: `pc + 4`; the link value for `jal`.
- `jump` in 1: from control.
- `branch` in 1: from control.
- `jal` in 1: from control.
- `zero` in 1: from ALU.
- `reg_target` in 32: rs value for the R-type register jump.
- `advance` in 1: datapath retires the current instruction this cycle.
- `fetch_err` out 1: misaligned target trap (see Configuration).

## Operation
- States: `FETCH`, `EXEC`, `HALT`.
- `FETCH`:
  - `imem_req`=1.
  - On `imem_ack`: `instr` <= `imem_rdata`; go to `EXEC`.
- `EXEC`:
  - `instr_valid`=1; `instr` and `pc` are stable.
  - On `advance`: `pc` <= next PC; go to `FETCH`.
  - `advance` is ignored in `FETCH` and `HALT`.
- Next PC, in priority order:
  1. `jump` & (`opcode` == R_TYPE): `reg_target`.
  2. `jump` | `jal`: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  3. `branch` & ~`zero` (BNE taken): `pc_plus4` + (sign-extended `instr[15:0]` << 2).
  4. Otherwise: `pc_plus4`.
- All arithmetic is 32-bit modulo 2^32. Example: `pc`=32'hFFFF_FFFC gives `pc_plus4`=0, no flag.
- `HALT`:
  - Entered only by a trap (see Configuration).
  - `imem_req`=0, `instr_valid`=0.
  - Left only by reset.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, `fetch_err`=0.
  - State `FETCH`; `imem_req` rises on the first edge after `rst_n` deasserts.
- Reset mid-fetch or mid-exec aborts immediately (asynchronous). `imem_req` drops with `rst_n`, and a pending ack is discarded.
- Handshake:
  - `imem_rdata` is sampled at the edge ending the ack cycle.
  - `imem_req` is 0 from the following cycle.
  - `instr_valid` rises the cycle after the ack.
- `advance` at an edge updates `pc` and reasserts `imem_req` at that same edge.
- Control outputs are sampled at the `advance` edge; `instr` is unchanged until the next ack.
- Minimum period is 2 cycles per instruction: ack in the first `FETCH` cycle, `advance` in the first `EXEC` cycle.
- `ack` while `imem_req`=0 is ignored.

## Configuration
- Macro: `FETCH_ALIGN_CHECK_EN`.
- Defined:
  - If the selected next PC has bits [1:0] != 0 at the `advance` edge, `pc` holds, `fetch_err`<=1 and the state goes to `HALT`.
  - `fetch_err` stays 1 until reset.
- Undefined:
  - No check; the next PC is loaded with bits [1:0] forced to 00.
  - `fetch_err` is tied to 0 and `HALT` is unreachable.

## Structure
- `mips_pkg` holds:
  - `fetch_state_t` enum (`FETCH`, `EXEC`, `HALT`).
  - The `RESET_PC` default.
  - Opcode constants taken from `mips_codes.sv` (R_TYPE, JAL, BNE).
- One combinational sub-module `next_pc_calc`:
  - Inputs: `pc_plus4`, `instr`, `jump`, `jal`, `branch`, `zero`, `reg_target`.
  - Outputs: next PC and the misaligned flag.
- The FSM, PC register and instruction register stay in `fetch_unit`.

## Test plan
- Reset then ack after 3 cycles with rdata=32'h2008_0005 (ADDI) → `imem_addr`=0, `instr_valid` rises the cycle after ack; `advance` → `pc`=4.
- BNE at `pc`=8, imm=16'hFFFE: `zero`=0 gives `pc`=4; `zero`=1 gives `pc`=12.
- JAL at `pc`=32'h1000_0010, target 26'h000_0040 → `pc_plus4`=32'h1000_0014 while executing; after `advance`, `pc`=32'h1000_0100.
- R-type `jump` with `reg_target`=32'h0000_0200 → `pc`=32'h200. With `reg_target`=32'h202 and the macro defined → `fetch_err`=1, `HALT`, `imem_req` stays 0.
- Ack in the same cycle as req, `advance` held high → new instruction every 2 cycles. `rst_n` low during `FETCH` → `imem_req` drops immediately, `pc`=`RESET_PC`.
- `pc`=32'hFFFF_FFFC sequential → next `pc`=0, `fetch_err`=0.
